fetch_sched: RTL and testbench
==============================

Name: fetch_sched

Overview:
Fetch scheduler for the dual-read-port combinational instruction memory. It drives both read addresses each cycle, fetching pc and pc+1 in parallel. Fetched words go into a small instruction queue, which hands one instruction per cycle to decode over a valid/ready handshake. The block also handles branch/jump redirects from execute, which flush the queue and reload the PC.

Parameters:
AW, 5, instruction address width (word addresses, 32 entries)
DW, 32, instruction width
DEPTH, 4, instruction queue entries; power of two, at least 2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
fetch_en  in  1  fetch enable; when low, no new fetches and pc holds
dir  out  AW  port-1 read address, equal to pc
dir2  out  AW  port-2 read address, equal to pc+1 mod 2^AW
ins  in  DW  instruction at dir, same cycle (memory is combinational)
ins2  in  DW  instruction at dir2, same cycle
redirect  in  1  branch/jump taken; flush the queue and load pc
redirect_pc  in  AW  new fetch address
out_valid  out  1  queue head valid
out_ins  out  DW  queue head instruction
out_pc  out  AW  address of the queue head instruction
out_ready  in  1  decode accepts the head

Behaviour:
- Reset (rst_n low at a clock edge): pc=0, count=0, rd_ptr=wr_ptr=0, all queue entries (ins and pc) cleared to 0.
- After reset: out_valid=0, out_ins=0, out_pc=0, dir=0, dir2=1.
- dir and dir2 are combinational from the pc register only. They do not depend on any input.
- out_valid = (count != 0). out_ins and out_pc are the entry at rd_ptr. All three derive from registers only.
- free = DEPTH - count, using the registered count. A dequeue in the same cycle does not create space for that cycle.
- Write rule, when fetch_en=1 and redirect=0:
  - free >= 2: write {ins, pc} then {ins2, pc+1}; pc <= pc+2.
  - free == 1: write {ins, pc} only; pc <= pc+1.
  - free == 0: no write; pc holds.
- When fetch_en=0, there are no writes and pc holds. The dequeue rule still applies.
- Dequeue: happens when out_valid && out_ready, and advances rd_ptr.
- Count update: count <= count + writes - deq.
- Address arithmetic is modulo 2^AW:
  - pc=31 gives dir2=0.
  - pc+2 from 31 gives 1.
  - pc+1 from 31 gives 0.
- Pointers wrap modulo DEPTH.
- Redirect has the highest priority. In that cycle:
  - No writes occur.
  - count <= 0, rd_ptr <= 0, wr_ptr <= 0, pc <= redirect_pc.
  - A handshake that completes in the same cycle is still accepted by decode. The queue is flushed regardless.
- Redirect latency:
  - Cycle after redirect: out_valid=0, and the fetch of redirect_pc and redirect_pc+1 is issued.
  - Following cycle: out_valid=1, out_pc=redirect_pc.
- Fetch-to-output latency is 1 cycle: a word written at edge N is visible at the head from edge N onward, if the queue was empty.
- Redirect and fetch_en=0 together: the redirect still flushes and loads pc.
- Reset overrides redirect and everything else.
- count never exceeds DEPTH and never underflows. The bench checks this with an assertion.

Decomposition:
- Package fetch_pkg:
  - constants AW, DW, DEPTH, and NOP = 32'h00000000;
  - typedef q_entry_t = {ins[DW], pc[AW]};
  - function addr_inc(a, k) for modulo pc arithmetic.
- Sub-module instr_queue: a FIFO with two write ports and one read port.
  - Inputs: wr_n (0..2), two entries, deq, flush.
  - Outputs: head entry and count.
- fetch_sched keeps the pc register, the free/write decision and redirect priority.

Test Plan:
All tests use a memory model returning 32'hA0000000 | addr on both ports.
1. Startup: release rst_n with fetch_en=1 and out_ready=1 held.
   -> Cycle 0: dir=0, dir2=1.
   -> Next cycle: out_valid=1, out_pc=0, out_ins=32'hA0000000.
   -> Accepted out_pc sequence is 0,1,2,3,... with no gaps.
2. Back-pressure: out_ready=0 after reset.
   -> After 2 cycles: count=4 and pc=4; dir stays 4.
   -> out_pc holds 0 until ready rises.
3. Single-slot fetch: from a full queue, pulse out_ready for 1 cycle.
   -> That cycle: no write, count=3.
   -> Next cycle: exactly one write (pc 4->5), entry out_pc=4, ins=32'hA0000004.
4. Redirect: with 3 entries queued, pulse redirect with redirect_pc=5'h18.
   -> Next cycle: out_valid=0, dir=5'h18, dir2=5'h19.
   -> Following cycle: out_pc=5'h18, out_ins=32'hA0000018, then 5'h19.
5. Wrap: redirect to 5'h1F with out_ready=1.
   -> dir=31, dir2=0; pc becomes 1.
   -> Accepted out_pc sequence: 31, 0, 1, 2.
6. Mid-run reset and enable: with the queue full, drive rst_n=0 for 1 cycle.
   -> out_valid=0, dir=0, count=0.
   -> Then with fetch_en=0 for 3 cycles: pc stays 0 and out_valid stays 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants, queue entry layout and pc arithmetic for the fetch scheduler.
package fetch_pkg;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;

    localparam logic [DW-1:0] NOP = 32'h00000000;

    typedef struct packed {
        logic [DW-1:0] ins;
        logic [AW-1:0] pc;
    } q_entry_t;

    // Word address arithmetic wraps modulo 2^AW.
    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a, input logic [1:0] k);
        return a + AW'(k);
    endfunction
endpackage

// File: rtl/instr_queue.sv
// Instruction queue: two write ports (in order, wr0 then wr1), one read port.
// flush empties the queue; pointers wrap naturally since DEPTH is a power of two.
module instr_queue
    import fetch_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    wr_n,
    input  q_entry_t      wr0,
    input  q_entry_t      wr1,
    input  logic          deq,
    input  logic          flush,
    output q_entry_t      head,
    output logic [CW-1:0] count
);
    q_entry_t        mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr, wr_ptr1;
    logic            deq_ok;

    assign head    = mem[rd_ptr];
    assign wr_ptr1 = wr_ptr + PW'(1);
    // Never pop an empty queue, whatever the caller drives.
    assign deq_ok  = deq && (count != '0);

    // Storage, pointers and occupancy; flush drops everything including writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '{ins: NOP, pc: '0};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_n != 2'd0) mem[wr_ptr]  <= wr0;
            if (wr_n == 2'd2) mem[wr_ptr1] <= wr1;
            wr_ptr <= wr_ptr + PW'(wr_n);
            rd_ptr <= rd_ptr + PW'(deq_ok);
            count  <= count + CW'(wr_n) - CW'(deq_ok);
        end
    end
endmodule

// File: rtl/fetch_sched.sv
// Fetch scheduler: reads pc and pc+1 from a dual-port combinational memory,
// enqueues as many words as the queue has room for (based on the registered
// count), and flushes/reloads on a redirect from execute.
module fetch_sched
    import fetch_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_en,
    output logic [AW-1:0] dir,
    output logic [AW-1:0] dir2,
    input  logic [DW-1:0] ins,
    input  logic [DW-1:0] ins2,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          out_valid,
    output logic [DW-1:0] out_ins,
    output logic [AW-1:0] out_pc,
    input  logic          out_ready
);
    logic [AW-1:0] pc;
    logic [CW-1:0] q_count, free;
    logic [1:0]    wr_n;
    logic          deq;
    q_entry_t      head;

    assign dir       = pc;
    assign dir2      = addr_inc(pc, 2'd1);
    assign out_valid = (q_count != '0);
    assign out_ins   = head.ins;
    assign out_pc    = head.pc;
    assign deq       = out_valid && out_ready;
    // A same-cycle dequeue does not free a slot for this cycle's fetch.
    assign free      = CW'(DEPTH) - q_count;

    // Number of fetched words to enqueue; redirect suppresses all writes.
    always_comb begin
        wr_n = 2'd0;
        if (fetch_en && !redirect) begin
            if (free >= CW'(2))      wr_n = 2'd2;
            else if (free == CW'(1)) wr_n = 2'd1;
        end
    end

    // pc advances by the number of words actually enqueued; redirect wins.
    always_ff @(posedge clk) begin
        if (!rst_n)        pc <= '0;
        else if (redirect) pc <= redirect_pc;
        else               pc <= addr_inc(pc, wr_n);
    end

    instr_queue u_q (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_n  (wr_n),
        .wr0   ('{ins: ins,  pc: pc}),
        .wr1   ('{ins: ins2, pc: dir2}),
        .deq   (deq),
        .flush (redirect),
        .head  (head),
        .count (q_count)
    );
endmodule

// File: tb/tb_fetch_sched.sv
// Bench for fetch_sched: directed scenarios plus random traffic, checked
// against a queue-level reference model; accepted instructions go through a
// scoreboard popped by an independent monitor.
module tb_fetch_sched;
    import fetch_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n, fetch_en, redirect, out_ready, out_valid;
    logic [AW-1:0] redirect_pc, dir, dir2, out_pc;
    logic [DW-1:0] ins, ins2, out_ins;

    int nt = 0, nf = 0;
    int mq[$];      // model queue contents (pc values)
    int mpc;        // model pc
    bit mok = 0;    // model state known (after first reset)
    int sb[$];      // expected accepted pcs

    always #5 clk = ~clk;

    assign ins  = 32'hA0000000 | {27'd0, dir};
    assign ins2 = 32'hA0000000 | {27'd0, dir2};

    fetch_sched dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .dir(dir), .dir2(dir2),
        .ins(ins), .ins2(ins2), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ins(out_ins), .out_pc(out_pc), .out_ready(out_ready)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nt++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: compare visible state with the model, predict acceptance,
    // advance the model by the spec rules, then move to the next falling edge.
    task automatic step();
        bit acc;
        int n;
        if (mok) begin
            chk("dir", dir, 64'(mpc));
            chk("dir2", dir2, 64'((mpc + 1) % 32));
            chk("out_valid", out_valid, 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("out_pc", out_pc, 64'(mq[0]));
                chk("out_ins", out_ins, 64'(32'hA0000000 | mq[0]));
            end
        end
        if (!rst_n) begin
            mq.delete();
            mpc = 0;
            mok = 1;
        end else if (mok) begin
            acc = (mq.size() != 0) && out_ready;
            if (acc) sb.push_back(mq[0]);
            if (redirect) begin
                mq.delete();
                mpc = int'(redirect_pc);
            end else begin
                n = 0;
                if (fetch_en) n = (DEPTH - mq.size() < 2) ? DEPTH - mq.size() : 2;
                if (acc) void'(mq.pop_front());
                for (int i = 0; i < n; i++) mq.push_back((mpc + i) % 32);
                mpc = (mpc + n) % 32;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: every completed handshake must match the next predicted accept.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            #1;
            if (mok && rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    nt++; nf++;
                    $display("FAIL unexpected_accept: got pc %0h expected none", out_pc);
                end else begin
                    e = sb.pop_front();
                    chk("acc_pc", out_pc, 64'(e));
                    chk("acc_ins", out_ins, 64'(32'hA0000000 | e));
                end
            end
        end
    end

    // Occupancy must stay within the queue.
    always @(negedge clk) begin
        if (mok && rst_n === 1'b1)
            assert (dut.q_count <= CW'(DEPTH)) else $error("FAIL count_bound: got %0d expected <= %0d", dut.q_count, DEPTH);
    end

    initial begin
        rst_n = 1'b0; fetch_en = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        @(negedge clk);
        step(); step();

        // Startup
        rst_n = 1'b1;
        chk("t1_dir", dir, 0); chk("t1_dir2", dir2, 1); chk("t1_vld0", out_valid, 0);
        step();
        chk("t1_vld1", out_valid, 1); chk("t1_pc", out_pc, 0); chk("t1_ins", out_ins, 64'h A0000000);
        repeat (8) step();

        // Back-pressure from reset
        rst_n = 1'b0; out_ready = 1'b0; step(); rst_n = 1'b1;
        step(); step();
        chk("t2_cnt", dut.q_count, 4); chk("t2_dir", dir, 4); chk("t2_pc", out_pc, 0);
        step(); step();
        chk("t2_dir_hold", dir, 4); chk("t2_pc_hold", out_pc, 0);

        // Single-slot fetch
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("t3_cnt", dut.q_count, 3); chk("t3_dir", dir, 4);
        step();
        chk("t3_cnt2", dut.q_count, 4); chk("t3_dir2", dir, 5);

        // Redirect with 3 entries queued
        fetch_en = 1'b0; out_ready = 1'b1; step(); out_ready = 1'b0; fetch_en = 1'b1;
        chk("t4_cnt", dut.q_count, 3);
        redirect = 1'b1; redirect_pc = 5'h18; step(); redirect = 1'b0;
        chk("t4_vld0", out_valid, 0); chk("t4_dir", dir, 5'h18); chk("t4_dir2", dir2, 5'h19);
        step();
        chk("t4_vld1", out_valid, 1); chk("t4_pc", out_pc, 5'h18); chk("t4_ins", out_ins, 64'h A0000018);
        out_ready = 1'b1; step();
        chk("t4_pc2", out_pc, 5'h19);

        // Wrap
        redirect = 1'b1; redirect_pc = 5'h1F; step(); redirect = 1'b0;
        chk("t5_dir", dir, 31); chk("t5_dir2", dir2, 0);
        step(); chk("t5_pcreg", dir, 1); chk("t5_h31", out_pc, 31);
        step(); chk("t5_h0", out_pc, 0);
        step(); chk("t5_h1", out_pc, 1);
        step(); chk("t5_h2", out_pc, 2);

        // Mid-run reset then fetch disabled
        out_ready = 1'b0; repeat (3) step();
        chk("t6_full", dut.q_count, 4);
        rst_n = 1'b0; step(); rst_n = 1'b1; fetch_en = 1'b0;
        chk("t6_vld", out_valid, 0); chk("t6_dir", dir, 0); chk("t6_cnt", dut.q_count, 0);
        repeat (3) begin
            step();
            chk("t6_dir_hold", dir, 0); chk("t6_vld_hold", out_valid, 0);
        end

        // Random traffic
        repeat (3000) begin
            rst_n       = ($urandom_range(63) != 0);
            redirect    = ($urandom_range(15) == 0);
            redirect_pc = 5'($urandom);
            fetch_en    = ($urandom_range(3) != 0);
            out_ready   = 1'($urandom_range(1));
            step();
        end
        rst_n = 1'b1; redirect = 1'b0; out_ready = 1'b0;
        #2;
        chk("sb_drained", 64'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end
endmodule
